// File: rtl/alu_decode_stage.sv
// Registered RV32I OP/OP-IMM decode stage producing a one-hot ALU control bundle.
// Optional macro ALU_DECODE_ILLEGAL_TRAP_EN: drop illegal instructions and pulse ILLEGAL.
module alu_decode_stage (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_INSTR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [9:0]  OUT_ALU_OP,
  output logic [4:0]  OUT_RS1,
  output logic [4:0]  OUT_RS2,
  output logic [4:0]  OUT_RD,
  output logic        OUT_USE_IMM,
  output logic [31:0] OUT_IMM,
  output logic        ILLEGAL,
  output logic [31:0] DECODE_COUNT
);
  localparam logic [9:0] OP_ADD  = 10'b00_0000_0001;
  localparam logic [9:0] OP_SUB  = 10'b00_0000_0010;
  localparam logic [9:0] OP_SLL  = 10'b00_0000_0100;
  localparam logic [9:0] OP_SLT  = 10'b00_0000_1000;
  localparam logic [9:0] OP_SLTU = 10'b00_0001_0000;
  localparam logic [9:0] OP_XOR  = 10'b00_0010_0000;
  localparam logic [9:0] OP_SRL  = 10'b00_0100_0000;
  localparam logic [9:0] OP_SRA  = 10'b00_1000_0000;
  localparam logic [9:0] OP_OR   = 10'b01_0000_0000;
  localparam logic [9:0] OP_AND  = 10'b10_0000_0000;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [9:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_use_imm, dec_legal;
  logic        in_xfer, out_xfer, load, ill_pulse;

  assign opcode = IN_INSTR[6:0];
  assign funct3 = IN_INSTR[14:12];
  assign funct7 = IN_INSTR[31:25];

  always_comb begin
    dec_op      = '0;
    dec_imm     = '0;
    dec_use_imm = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec_op = OP_SUB;
          else if (funct3 == 3'b101) dec_op = OP_SRA;
        end
      end
      7'b0010011: begin
        dec_use_imm = 1'b1;
        dec_imm     = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            // shift amounts are never sign-extended
            dec_imm = {27'b0, IN_INSTR[24:20]};
            if (funct7 == 7'b0000000) dec_op = OP_SLL;
          end
          default: begin
            dec_imm = {27'b0, IN_INSTR[24:20]};
            if (funct7 == 7'b0000000)      dec_op = OP_SRL;
            else if (funct7 == 7'b0100000) dec_op = OP_SRA;
          end
        endcase
      end
      default: ;
    endcase
    dec_legal = |dec_op;
    // illegal words travel as a plain register-register bundle with no op
    if (!dec_legal) begin
      dec_use_imm = 1'b0;
      dec_imm     = '0;
    end
  end

  assign IN_READY = !OUT_VALID || OUT_READY;
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = OUT_VALID && OUT_READY;

`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  assign load      = in_xfer && dec_legal;
  assign ill_pulse = in_xfer && !dec_legal;
`else
  assign load      = in_xfer;
  assign ill_pulse = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OUT_VALID    <= 1'b0;
      OUT_ALU_OP   <= '0;
      OUT_RS1      <= '0;
      OUT_RS2      <= '0;
      OUT_RD       <= '0;
      OUT_USE_IMM  <= 1'b0;
      OUT_IMM      <= '0;
      ILLEGAL      <= 1'b0;
      DECODE_COUNT <= '0;
    end else begin
      ILLEGAL <= ill_pulse;
      if (load) begin
        OUT_VALID   <= 1'b1;
        OUT_ALU_OP  <= dec_op;
        OUT_RS1     <= IN_INSTR[19:15];
        OUT_RS2     <= dec_use_imm ? 5'd0 : IN_INSTR[24:20];
        OUT_RD      <= IN_INSTR[11:7];
        OUT_USE_IMM <= dec_use_imm;
        OUT_IMM     <= dec_imm;
      end else if (out_xfer) begin
        OUT_VALID <= 1'b0;
      end
      if (out_xfer) DECODE_COUNT <= DECODE_COUNT + 32'd1;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: random + directed RV32I words vs a mnemonic-level model.
module tb_alu_decode_stage;
  logic        CLK, RSTN, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_USE_IMM, ILLEGAL;
  logic [31:0] IN_INSTR, OUT_IMM, DECODE_COUNT;
  logic [9:0]  OUT_ALU_OP;
  logic [4:0]  OUT_RS1, OUT_RS2, OUT_RD;

  alu_decode_stage dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ALU_OP(OUT_ALU_OP), .OUT_RS1(OUT_RS1),
    .OUT_RS2(OUT_RS2), .OUT_RD(OUT_RD), .OUT_USE_IMM(OUT_USE_IMM), .OUT_IMM(OUT_IMM),
    .ILLEGAL(ILLEGAL), .DECODE_COUNT(DECODE_COUNT));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
    logic [31:0] imm;
    logic        legal;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  logic [31:0] cnt = 0;
  logic        ill_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: mnemonic index per funct3, then one-hot = 1 << index
  function automatic exp_t model(input logic [31:0] w);
    int   base_idx[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   idx = -1;
    int   f3 = int'(w[14:12]);
    int   f7 = int'(w[31:25]);
    int   opc = int'(w[6:0]);
    int   i12 = int'(w[31:20]);
    exp_t e;
    e.rs1 = w[19:15]; e.rd = w[11:7]; e.rs2 = w[24:20];
    e.use_imm = 1'b0; e.imm = 0;
    if (opc == 'h33) begin
      if (f7 == 0) idx = base_idx[f3];
      else if (f7 == 'h20 && f3 == 0) idx = 1;
      else if (f7 == 'h20 && f3 == 5) idx = 7;
    end else if (opc == 'h13) begin
      e.use_imm = 1'b1; e.rs2 = 0;
      if (f3 == 1 || f3 == 5) begin
        e.imm = w[24:20];
        if (f7 == 0) idx = (f3 == 1) ? 2 : 6;
        else if (f7 == 'h20 && f3 == 5) idx = 7;
      end else begin
        idx = base_idx[f3];
        e.imm = 32'((i12 >= 2048) ? i12 - 4096 : i12);
      end
    end
    e.legal = (idx >= 0);
    if (e.legal) e.op = 10'(1 << idx);
    else begin
      e.op = 0; e.rs2 = w[24:20]; e.use_imm = 1'b0; e.imm = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r = $urandom;
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    logic [6:0]  f7;
    case ($urandom_range(0, 4))
      0: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, r[24:15], f3, r[11:7], 7'h33};
      end
      1: return {r[31:15], f3, r[11:7], 7'h13};
      2: begin
        f7 = ($urandom_range(0, 2) == 0) ? 7'h00 : ($urandom_range(0, 1) == 1) ? 7'h20 : r[31:25];
        return {f7, r[24:15], f3, r[11:7], 7'h13};
      end
      3: return {r[31:15], f3, r[11:7], 5'b01100, r[1:0]};
      default: return r;
    endcase
  endfunction

  always @(negedge CLK) begin
    exp_t h, e;
    if (RSTN) begin
      chk("in_ready", {31'b0, IN_READY}, {31'b0, !OUT_VALID || OUT_READY});
      chk("illegal", {31'b0, ILLEGAL}, {31'b0, ill_pend});
      chk("decode_count", DECODE_COUNT, cnt);
      if (OUT_VALID) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          h = q[0];
          chk("alu_op", {22'b0, OUT_ALU_OP}, {22'b0, h.op});
          chk("rs1", {27'b0, OUT_RS1}, {27'b0, h.rs1});
          chk("rs2", {27'b0, OUT_RS2}, {27'b0, h.rs2});
          chk("rd", {27'b0, OUT_RD}, {27'b0, h.rd});
          chk("use_imm", {31'b0, OUT_USE_IMM}, {31'b0, h.use_imm});
          chk("imm", OUT_IMM, h.imm);
        end
        if (OUT_READY) begin
          if (q.size() != 0) void'(q.pop_front());
          cnt = cnt + 1;
        end
      end
      ill_pend = 1'b0;
      if (IN_VALID && IN_READY) begin
        e = model(IN_INSTR);
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
        if (!e.legal) ill_pend = 1'b1;
        else q.push_back(e);
`else
        q.push_back(e);
`endif
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] w, input logic r);
    IN_VALID = v; IN_INSTR = w; OUT_READY = r;
    @(posedge CLK); #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_out_valid"}, {31'b0, OUT_VALID}, 32'd0);
    chk({nm, "_alu_op"}, {22'b0, OUT_ALU_OP}, 32'd0);
    chk({nm, "_regs"}, {17'b0, OUT_RS1, OUT_RS2, OUT_RD}, 32'd0);
    chk({nm, "_imm"}, OUT_IMM | {31'b0, OUT_USE_IMM}, 32'd0);
    chk({nm, "_illegal"}, {31'b0, ILLEGAL}, 32'd0);
    chk({nm, "_count"}, DECODE_COUNT, 32'd0);
    chk({nm, "_in_ready"}, {31'b0, IN_READY}, 32'd1);
  endtask

  initial begin
    RSTN = 1'b0; IN_VALID = 1'b0; IN_INSTR = '0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_zero("reset");
    RSTN = 1'b1;
    @(posedge CLK); #1;

    cyc(1, 32'h00A302B3, 1);  // add x5,x6,x10
    cyc(1, 32'hFFF10093, 1);  // addi x1,x2,-1
    cyc(1, 32'h41F25193, 1);  // srai x3,x4,31
    cyc(1, 32'h02000033, 1);  // funct7 0000001: illegal
    cyc(1, 32'h00000013, 1);
    cyc(0, 32'h0, 1);

    for (int i = 0; i < 10; i++)
      cyc(1, {7'h00, 5'(i + 1), 5'(i + 2), 3'(i), 5'(i + 3), 7'h33}, 1);
    cyc(0, 32'h0, 1);

    cyc(1, 32'h40B50533, 0);  // sub x10,x10,x11 then stall
    for (int i = 0; i < 3; i++) cyc(1, 32'h0062F233, 0);
    cyc(1, 32'h0062F233, 1);
    cyc(0, 32'h0, 1);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 3) != 0);
    repeat (3) cyc(0, 32'h0, 1);
    chk("drained", q.size(), 32'd0);

    RSTN = 1'b0;
    #1;
    q.delete(); cnt = 0; ill_pend = 0;
    @(posedge CLK); #1 RSTN = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 6; i++) cyc(1, {12'(i * 7), 5'(i), 3'b000, 5'(i + 1), 7'h13}, 1);
    cyc(0, 32'h0, 0);
    chk("pre_reset_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("pre_reset_count", DECODE_COUNT, 32'd5);
    #2 RSTN = 1'b0;
    #1 check_zero("mid_reset");
    q.delete(); cnt = 0; ill_pend = 0;
    @(posedge CLK); #1 RSTN = 1'b1;
    cyc(1, 32'h00A302B3, 1);
    cyc(0, 32'h0, 1);
    chk("post_reset_count", DECODE_COUNT, 32'd1);
    chk("final_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that produces the ALU control bundle. Accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes OP and OP-IMM instructions into a one-hot ALU operation vector, register indices and an operand-B immediate. Outputs are presented one cycle later over a second valid/ready handshake to the operand-read/ALU stage. Sits between fetch and the ALU in the core pipeline.

## Interface
- No parameters.
- CLK  input  1  clock; all state updates on rising edge
- RSTN  input  1  asynchronous active-low reset
- IN_VALID  input  1  IN_INSTR holds an instruction
- IN_READY  output  1  stage can accept; combinational: !OUT_VALID || OUT_READY
- IN_INSTR  input  32  instruction word
- OUT_VALID  output  1  output bundle valid
- OUT_READY  input  1  downstream accepts bundle
- OUT_ALU_OP  output  10  one-hot op: [0]add [1]sub [2]sll [3]slt [4]sltu [5]xor [6]srl [7]sra [8]or [9]and
- OUT_RS1  output  5  instr[19:15]
- OUT_RS2  output  5  instr[24:20]; 0 when OUT_USE_IMM
- OUT_RD  output  5  instr[11:7]
- OUT_USE_IMM  output  1  operand B is OUT_IMM, not RS2 value
- OUT_IMM  output  32  operand-B immediate
- ILLEGAL  output  1  one-cycle pulse per rejected instruction (see Configuration)
- DECODE_COUNT  output  32  count of bundles accepted downstream

## Operation
- Transfer in: IN_VALID && IN_READY at rising edge. Transfer out: OUT_VALID && OUT_READY.
- On input transfer, decoded fields are registered and OUT_VALID set. On output transfer with no input transfer, OUT_VALID cleared. Simultaneous in/out transfer: register reloads, OUT_VALID stays 1.
- Output registers hold stable while OUT_VALID && !OUT_READY.
- OP (opcode 0110011): funct7 0000000 -> funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and. funct7 0100000 -> funct3 000 sub, 101 sra. Anything else illegal. OUT_USE_IMM=0.
- OP-IMM (opcode 0010011): funct3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and; OUT_IMM = sign-extended instr[31:20]. funct3 001 sll only if instr[31:25]=0000000; 101 srl if 0000000, sra if 0100000; shifts set OUT_IMM = {27'b0, instr[24:20]} (zero-extended shamt, never sign-extended). Other shift funct7 illegal. OUT_USE_IMM=1.
- Any other opcode, or instr[1:0] != 11: illegal.
- Exactly one OUT_ALU_OP bit set for every legal bundle.
- DECODE_COUNT increments by 1 per output transfer; wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (async, RSTN low): OUT_VALID=0, OUT_ALU_OP=0, OUT_RS1/RS2/RD=0, OUT_USE_IMM=0, OUT_IMM=0, ILLEGAL=0, DECODE_COUNT=0. IN_READY=1 during and after reset.
- Latency: 1 cycle input transfer -> OUT_VALID.
- Throughput: 1 instruction/cycle with OUT_READY held high.
- Backpressure: OUT_READY low with OUT_VALID high -> IN_READY low same cycle; no input consumed.
- ILLEGAL asserts the cycle after the offending input transfer, for exactly one cycle.
- Reset mid-transfer: bundle discarded, no partial output, count cleared.

## Configuration
- ALU_DECODE_ILLEGAL_TRAP_EN defined: illegal instructions are consumed (IN_READY behaviour unchanged), produce no output bundle (OUT_VALID unaffected by that transfer, i.e. cleared if no retained bundle), and pulse ILLEGAL.
- Not defined: illegal instructions are forwarded as a normal bundle with OUT_ALU_OP=0 (downstream ALU result 0), fields extracted as for OP, OUT_USE_IMM=0; ILLEGAL tied 0; such bundles counted in DECODE_COUNT.

## Test plan
- After reset, instr 0x00A302B3 (add x5,x6,x10), OUT_READY=1 -> next cycle OUT_VALID=1, OUT_ALU_OP=0x001, RS1=6, RS2=10, RD=5, USE_IMM=0; DECODE_COUNT=1 after.
- addi x1,x2,-1 (0xFFF10093) -> ALU_OP=0x001, USE_IMM=1, OUT_IMM=0xFFFFFFFF; srai x3,x4,31 (0x41F25193) -> ALU_OP=0x080, OUT_IMM=0x0000001F.
- Back-to-back stream of 10 distinct OP instrs, OUT_READY=1 -> 10 bundles on consecutive cycles, in order, count=10.
- Hold OUT_READY=0 for 3 cycles with valid bundle pending -> IN_READY=0, outputs stable; release -> bundle taken, next input accepted same cycle.
- Macro defined: instr 0x02000033 (funct7 0000001) -> ILLEGAL pulses 1 cycle, no OUT_VALID, count unchanged; macro undefined -> bundle with ALU_OP=0, count+1.
- Assert RSTN low while OUT_VALID=1 and count=5 -> all outputs zero immediately, IN_READY=1.
